// File: rtl/md_audio_pkg.sv
// Shared constants, slot-decode enum and the output saturation helper for md_audio_mix.
package md_audio_pkg;

  localparam int unsigned FM_SLOTS     = 6;
  localparam logic [2:0]  FM_LAST_SLOT = 3'd5;
  localparam logic [15:0] PSG_MID      = 16'h8000;
  localparam int unsigned ACC_W        = 13;
  localparam int unsigned MIX_W        = 18;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_LOAD,
    OP_ADD,
    OP_DONE,
    OP_DROP
  } slot_op_e;

  function automatic logic [15:0] sat16(input logic signed [MIX_W-1:0] s);
    logic [15:0] r;
    if (s > 18'sd32767)       r = 16'h7FFF;
    else if (s < -18'sd32768) r = 16'h8000;
    else                      r = s[15:0];
    return r;
  endfunction

endpackage

// File: rtl/md_audio_mix_if.sv
// FM slot bus and PSG level bus feeding the audio mixer.
interface md_audio_mix_if;

  logic        fm_clk1;
  logic [2:0]  DAC_ch_index;
  logic [9:0]  MOL_2612;
  logic [9:0]  MOR_2612;
  logic        vdp_psg_clk1;
  logic [15:0] PSG;

  modport master (
    output fm_clk1, DAC_ch_index, MOL_2612, MOR_2612, vdp_psg_clk1, PSG
  );

  modport slave (
    input fm_clk1, DAC_ch_index, MOL_2612, MOR_2612, vdp_psg_clk1, PSG
  );

endinterface

// File: rtl/md_fm_slot_acc.sv
// Accumulates the six time-multiplexed FM slots into one L/R frame sum.
// One slot mask and drop counter serve both sides.
module md_fm_slot_acc
  import md_audio_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    slot_stb,
  input  logic [2:0]              slot_idx,
  input  logic signed [9:0]       slot_l,
  input  logic signed [9:0]       slot_r,
  output logic signed [ACC_W-1:0] fm_sum_l,
  output logic signed [ACC_W-1:0] fm_sum_r,
  output logic                    frame_done,
  output logic [7:0]              drop_cnt
);

  slot_op_e                op;
  logic [FM_SLOTS-1:0]     mask;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [ACC_W-1:0] ext_l, ext_r;

  always_comb begin
    ext_l = {{(ACC_W-10){slot_l[9]}}, slot_l};
    ext_r = {{(ACC_W-10){slot_r[9]}}, slot_r};
    op    = OP_IDLE;
    if (slot_stb) begin
      if (slot_idx == '0)
        op = OP_LOAD;
      else if (slot_idx < FM_LAST_SLOT)
        op = OP_ADD;
      else if (slot_idx == FM_LAST_SLOT)
        op = (&mask[FM_SLOTS-2:0]) ? OP_DONE : OP_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_l      <= '0;
      acc_r      <= '0;
      mask       <= '0;
      fm_sum_l   <= '0;
      fm_sum_r   <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (op)
        OP_LOAD: begin
          // Index 0 always restarts; any partial frame is dropped silently.
          acc_l <= ext_l;
          acc_r <= ext_r;
          mask  <= FM_SLOTS'(1);
        end
        OP_ADD: begin
          acc_l          <= acc_l + ext_l;
          acc_r          <= acc_r + ext_r;
          mask[slot_idx] <= 1'b1;
        end
        OP_DONE: begin
          fm_sum_l   <= acc_l + ext_l;
          fm_sum_r   <= acc_r + ext_r;
          frame_done <= 1'b1;
          acc_l      <= '0;
          acc_r      <= '0;
          mask       <= '0;
        end
        OP_DROP: begin
          acc_l <= '0;
          acc_r <= '0;
          mask  <= '0;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_audio_mix.sv
// FM + PSG stereo mixer: frame accumulate, DC-removed PSG, mix, 16-bit saturation.
// Result is valid two MCLK edges after the slot-5 strobe.
module md_audio_mix
  import md_audio_pkg::*;
#(
  parameter int unsigned FM_SHIFT  = 4,
  parameter int unsigned PSG_SHIFT = 2
) (
  input  logic              MCLK,
  input  logic              SRES,
  md_audio_mix_if.slave     bus,
  input  logic              fm_en,
  input  logic              psg_en,
  output logic [15:0]       out_l,
  output logic [15:0]       out_r,
  output logic              out_valid,
  output logic [7:0]        drop_cnt
);

  logic signed [ACC_W-1:0] fm_sum_l, fm_sum_r;
  logic                    frame_done;
  logic [15:0]             psg_reg;
  logic [15:0]             psg_diff;
  logic signed [15:0]      psg_s;
  logic signed [MIX_W-1:0] fm_term_l, fm_term_r, psg_term;
  logic signed [MIX_W-1:0] mix_l, mix_r;
  logic                    mix_vld;

  md_fm_slot_acc u_acc (
    .clk        (MCLK),
    .rst_n      (SRES),
    .slot_stb   (bus.fm_clk1),
    .slot_idx   (bus.DAC_ch_index),
    .slot_l     (bus.MOL_2612),
    .slot_r     (bus.MOR_2612),
    .fm_sum_l   (fm_sum_l),
    .fm_sum_r   (fm_sum_r),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always_comb begin
    psg_diff  = psg_reg - PSG_MID;
    psg_s     = $signed(psg_diff) >>> PSG_SHIFT;
    psg_term  = '0;
    fm_term_l = '0;
    fm_term_r = '0;
    if (psg_en) psg_term = {{(MIX_W-16){psg_s[15]}}, psg_s};
    if (fm_en) begin
      fm_term_l = {{(MIX_W-ACC_W){fm_sum_l[ACC_W-1]}}, fm_sum_l} <<< FM_SHIFT;
      fm_term_r = {{(MIX_W-ACC_W){fm_sum_r[ACC_W-1]}}, fm_sum_r} <<< FM_SHIFT;
    end
  end

  // psg_reg is read before its own update, so a same-cycle strobe mixes the old level.
  always_ff @(posedge MCLK) begin
    if (!SRES) begin
      psg_reg   <= '0;
      mix_l     <= '0;
      mix_r     <= '0;
      mix_vld   <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (bus.vdp_psg_clk1) psg_reg <= bus.PSG;
      mix_vld <= frame_done;
      if (frame_done) begin
        mix_l <= fm_term_l + psg_term;
        mix_r <= fm_term_r + psg_term;
      end
      out_valid <= mix_vld;
      if (mix_vld) begin
        out_l <= sat16(mix_l);
        out_r <= sat16(mix_r);
      end
    end
  end

endmodule

// File: tb/tb_md_audio_mix.sv
// Self-checking bench for md_audio_mix: vector table, corner sequences, random frames vs model.
module tb_md_audio_mix;

  localparam int FM_SH  = 4;
  localparam int PSG_SH = 2;

  logic        MCLK = 1'b0;
  logic        SRES = 1'b0;
  logic        fm_en = 1'b0;
  logic        psg_en = 1'b0;
  logic [15:0] out_l, out_r;
  logic        out_valid;
  logic [7:0]  drop_cnt;

  md_audio_mix_if bus ();

  md_audio_mix #(
    .FM_SHIFT  (FM_SH),
    .PSG_SHIFT (PSG_SH)
  ) dut (
    .MCLK      (MCLK),
    .SRES      (SRES),
    .bus       (bus),
    .fm_en     (fm_en),
    .psg_en    (psg_en),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .drop_cnt  (drop_cnt)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  l;
    logic [9:0]  r;
    logic [15:0] psg;
    bit          fe;
    bit          pe;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic slot(input logic [2:0] idx, input logic [9:0] l, input logic [9:0] r);
    bus.fm_clk1      = 1'b1;
    bus.DAC_ch_index = idx;
    bus.MOL_2612     = l;
    bus.MOR_2612     = r;
    tick();
    bus.fm_clk1      = 1'b0;
    bus.DAC_ch_index = 3'd7;
  endtask

  task automatic psg_set(input logic [15:0] v);
    bus.vdp_psg_clk1 = 1'b1;
    bus.PSG          = v;
    tick();
    bus.vdp_psg_clk1 = 1'b0;
  endtask

  task automatic full_frame(input logic [9:0] l, input logic [9:0] r);
    for (int i = 0; i < 6; i++) slot(3'(i), l, r);
  endtask

  // Called right after the slot-5 strobe edge.
  task automatic expect_out(input string name, input logic [15:0] el, input logic [15:0] er);
    tick();
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_l"}, 32'(out_l), 32'(el));
    chk({name, "_r"}, 32'(out_r), 32'(er));
    tick();
    chk({name, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  task automatic expect_none(input string name);
    int seen;
    seen = 0;
    repeat (3) begin
      tick();
      if (out_valid) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  function automatic int sv10(input logic [9:0] v);
    return v[9] ? int'(v) - 1024 : int'(v);
  endfunction

  function automatic logic [15:0] model(input int fm_sum, input int psg, input bit fe, input bit pe);
    int f, p, s;
    f = fe ? fm_sum * (1 << FM_SH) : 0;
    p = (psg - 32768) >>> PSG_SH;
    if (!pe) p = 0;
    s = f + p;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int exp_drop;

    tbl[0] = '{10'd100,  10'd100,  16'h9000, 1'b1, 1'b1, 16'h2980, 16'h2980};
    tbl[1] = '{10'h1FF,  10'h1FF,  16'h8000, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF};
    tbl[2] = '{10'h200,  10'h200,  16'h8000, 1'b1, 1'b1, 16'h8000, 16'h8000};
    tbl[3] = '{10'd100,  10'h3F6,  16'h8000, 1'b1, 1'b1, 16'h2580, 16'hFC40};
    tbl[4] = '{10'd50,   10'd50,   16'h0000, 1'b0, 1'b1, 16'hE000, 16'hE000};
    tbl[5] = '{10'd50,   10'd50,   16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{10'd10,   10'd10,   16'hFFFF, 1'b1, 1'b1, 16'h23BF, 16'h23BF};
    tbl[7] = '{10'h1FF,  10'h200,  16'h8000, 1'b1, 1'b1, 16'h7FFF, 16'h8000};

    bus.fm_clk1      = 1'b0;
    bus.DAC_ch_index = 3'd7;
    bus.MOL_2612     = '0;
    bus.MOR_2612     = '0;
    bus.vdp_psg_clk1 = 1'b0;
    bus.PSG          = '0;

    repeat (3) tick();
    chk("rst_out_l", 32'(out_l), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    SRES = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      fm_en  = tbl[i].fe;
      psg_en = tbl[i].pe;
      psg_set(tbl[i].psg);
      full_frame(tbl[i].l, tbl[i].r);
      expect_out($sformatf("vec%0d", i), tbl[i].el, tbl[i].er);
    end
    chk("vec_drop", 32'(drop_cnt), 32'd0);

    // PSG strobe coinciding with the mix cycle must not affect that sample.
    fm_en  = 1'b0;
    psg_en = 1'b1;
    psg_set(16'h0000);
    full_frame(10'd1, 10'd1);
    bus.vdp_psg_clk1 = 1'b1;
    bus.PSG          = 16'hFFFF;
    tick();
    bus.vdp_psg_clk1 = 1'b0;
    chk("psg_race_early", 32'(out_valid), 32'd0);
    tick();
    chk("psg_race_valid", 32'(out_valid), 32'd1);
    chk("psg_race_l", 32'(out_l), 32'hE000);
    chk("psg_race_r", 32'(out_r), 32'hE000);
    full_frame(10'd1, 10'd1);
    expect_out("psg_new", 16'h1FFF, 16'h1FFF);

    // Restart mid-frame, idle indices interleaved.
    fm_en  = 1'b1;
    psg_en = 1'b1;
    psg_set(16'h8000);
    slot(3'd0, 10'd50, 10'd50);
    slot(3'd1, 10'd50, 10'd50);
    slot(3'd6, 10'd300, 10'd300);
    slot(3'd2, 10'd50, 10'd50);
    slot(3'd0, 10'd10, 10'd10);
    slot(3'd7, 10'd77, 10'd77);
    slot(3'd1, 10'd10, 10'd10);
    slot(3'd2, 10'd10, 10'd10);
    slot(3'd6, 10'h1FF, 10'h200);
    slot(3'd3, 10'd10, 10'd10);
    slot(3'd4, 10'd10, 10'd10);
    slot(3'd7, 10'd5, 10'd5);
    slot(3'd5, 10'd10, 10'd10);
    expect_out("restart", 16'h03C0, 16'h03C0);
    chk("restart_drop", 32'(drop_cnt), 32'd0);

    // Incomplete frame, then a frame with a repeated index.
    slot(3'd0, 10'd5, 10'd5);
    slot(3'd1, 10'd5, 10'd5);
    slot(3'd2, 10'd5, 10'd5);
    slot(3'd5, 10'd5, 10'd5);
    expect_none("drop_novalid");
    chk("drop_one", 32'(drop_cnt), 32'd1);
    slot(3'd0, 10'd1, 10'd1);
    slot(3'd1, 10'd1, 10'd1);
    slot(3'd1, 10'd1, 10'd1);
    slot(3'd2, 10'd1, 10'd1);
    slot(3'd3, 10'd1, 10'd1);
    slot(3'd4, 10'd1, 10'd1);
    slot(3'd5, 10'd1, 10'd1);
    expect_out("repeat_idx", 16'h0070, 16'h0070);
    chk("repeat_drop", 32'(drop_cnt), 32'd1);

    repeat (253) slot(3'd5, 10'd1, 10'd1);
    chk("drop_254", 32'(drop_cnt), 32'd254);
    slot(3'd5, 10'd1, 10'd1);
    chk("drop_255", 32'(drop_cnt), 32'd255);
    slot(3'd5, 10'd1, 10'd1);
    slot(3'd5, 10'd1, 10'd1);
    chk("drop_hold", 32'(drop_cnt), 32'd255);
    chk("drop_hold_l", 32'(out_l), 32'h0070);

    // Reset in the middle of a frame.
    slot(3'd0, 10'd1, 10'd1);
    slot(3'd1, 10'd1, 10'd1);
    slot(3'd2, 10'd1, 10'd1);
    slot(3'd3, 10'd1, 10'd1);
    SRES = 1'b0;
    tick();
    chk("mid_rst_l",     32'(out_l), 32'd0);
    chk("mid_rst_r",     32'(out_r), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drop",  32'(drop_cnt), 32'd0);
    SRES = 1'b1;
    psg_set(16'h8000);
    full_frame(10'd1, 10'd1);
    expect_out("post_rst", 16'h0060, 16'h0060);
    chk("post_rst_drop", 32'(drop_cnt), 32'd0);

    // Randomised frames against the reference model.
    exp_drop = 0;
    for (int f = 0; f < 60; f++) begin
      int   psgv, sum_l, sum_r, n;
      bit   fe, pe;
      logic [3:0] seen;
      int   order[4];
      logic [9:0] vl, vr;

      fe   = 1'($urandom_range(0, 1));
      pe   = 1'($urandom_range(0, 1));
      psgv = int'($urandom_range(0, 65535));
      fm_en  = fe;
      psg_en = pe;
      psg_set(16'(psgv));

      vl = 10'($urandom); vr = 10'($urandom);
      slot(3'd0, vl, vr);
      sum_l = sv10(vl);
      sum_r = sv10(vr);
      seen  = '0;

      if ($urandom_range(0, 1) == 1) begin
        order = '{1, 2, 3, 4};
        for (int k = 3; k > 0; k--) begin
          int j, t;
          j = int'($urandom_range(0, k));
          t = order[k]; order[k] = order[j]; order[j] = t;
        end
        n = 4;
      end else begin
        n = int'($urandom_range(1, 4));
        for (int k = 0; k < 4; k++) order[k] = int'($urandom_range(1, 4));
      end

      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0)
          slot(3'($urandom_range(6, 7)), 10'($urandom), 10'($urandom));
        vl = 10'($urandom); vr = 10'($urandom);
        slot(3'(order[k]), vl, vr);
        sum_l += sv10(vl);
        sum_r += sv10(vr);
        seen[order[k]-1] = 1'b1;
      end

      vl = 10'($urandom); vr = 10'($urandom);
      slot(3'd5, vl, vr);
      sum_l += sv10(vl);
      sum_r += sv10(vr);

      if (&seen) begin
        expect_out($sformatf("rnd%0d", f), model(sum_l, psgv, fe, pe), model(sum_r, psgv, fe, pe));
      end else begin
        if (exp_drop < 255) exp_drop++;
        expect_none($sformatf("rnd%0d_none", f));
      end
      chk($sformatf("rnd%0d_drop", f), 32'(drop_cnt), 32'(exp_drop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_audio_mix.md
Name: md_audio_mix

Overview:
- Downstream audio stage of the chipset top.
- Consumes the time-multiplexed per-channel FM DAC outputs (MOL_2612/MOR_2612 with DAC_ch_index, strobed by fm_clk1) and the VDP PSG output (strobed by vdp_psg_clk1).
- Accumulates the six FM channel slots into one stereo sample, removes the PSG DC offset and mixes both sources.
- Saturates to 16-bit signed stereo and emits one valid pulse per FM output sample. The pulse feeds the board audio path / resampler.

Parameters:
FM_SHIFT, 4, left shift applied to the 6-slot FM sum; legal range 0..4.
PSG_SHIFT, 2, arithmetic right shift applied to the DC-removed PSG value; legal range 0..15.

Ports:
MCLK  in  1  master clock; the only clock.
SRES  in  1  synchronous, active-low reset.
fm_clk1  in  1  FM slot strobe, 1-MCLK enable.
DAC_ch_index  in  3  FM slot index; 0..5 valid, 6..7 idle.
MOL_2612  in  10  FM left slot value, two's complement.
MOR_2612  in  10  FM right slot value, two's complement.
vdp_psg_clk1  in  1  PSG update strobe, 1-MCLK enable.
PSG  in  16  PSG level, unsigned, midpoint 16'h8000.
fm_en  in  1  1 = FM contributes to the mix; 0 = FM term forced to 0.
psg_en  in  1  1 = PSG contributes to the mix; 0 = PSG term forced to 0.
out_l  out  16  mixed left sample, signed.
out_r  out  16  mixed right sample, signed.
out_valid  out  1  1-MCLK pulse; out_l/out_r are new on this cycle.
drop_cnt  out  8  saturating count of FM frames discarded for incomplete slot coverage.

Behaviour:
- Reset: SRES low at a MCLK edge clears everything to 0 on that edge.
  - Cleared: accumulators, slot mask, PSG register, pipeline, out_l, out_r, out_valid, drop_cnt.
  - A frame in progress when reset is asserted is lost; it is not counted as a drop.
- Only cycles with fm_clk1=1 affect FM state. With fm_clk1=1:
  - Index 6/7: ignored.
  - Index 0: acc_l/acc_r (13-bit signed) load the sign-extended slot value; mask = 6'b000001. This restarts the frame even mid-frame, and the prior partial frame is discarded silently.
  - Index 1..4: acc += sign-extended slot value; mask[idx] set.
  - Index 5, with mask[4:0]==5'h1F: fm_sum = acc + current value is registered and stage-1 valid asserts. acc and mask clear.
  - Index 5, with mask incomplete: no sample is produced; drop_cnt increments and holds at 255; acc and mask clear.
  - A repeated index within a frame is added again; only a missing index causes a drop.
- PSG: on vdp_psg_clk1=1, psg_reg <= PSG.
  - psg_s = ($signed(psg_reg - 16'h8000)) >>> PSG_SHIFT, 16-bit signed.
  - If the PSG strobe and a mix calculation fall on the same cycle, the mix uses the psg_reg value from before the update.
- Mix stage, on the cycle after stage-1 valid:
  - fm_term = fm_en ? (fm_sum <<< FM_SHIFT) : 0, 17-bit signed.
  - psg_term = psg_en ? psg_s : 0.
  - s = fm_term + psg_term, 18-bit signed; computed separately for L and R with the same psg_term.
  - Saturation: s > 32767 gives 16'h7FFF; s < -32768 gives 16'h8000; otherwise s[15:0].
  - out_l/out_r register the result and out_valid pulses for one cycle.
- Latency: the index-5 fm_clk1 cycle is edge N; stage-1 registers at edge N; out_valid is high after edge N+2.
- out_l/out_r hold their value between valid pulses.
- fm_en and psg_en are sampled only in the mix stage.
- Width guarantees: |6-slot sum| ≤ 3072 fits 13 bits; with FM_SHIFT ≤ 4, fm_term fits 17 bits; s never overflows 18 bits.

Decomposition:
- Shared package md_audio_pkg holds:
  - FM_SLOTS=6 and FM_LAST_SLOT=3'd5.
  - PSG_MID=16'h8000.
  - Width constants ACC_W=13, MIX_W=18.
  - A function sat16(input signed [17:0]).
- One natural sub-module: md_fm_slot_acc. It covers the per-side accumulator plus a shared mask/drop handler and is instantiated for L/R. It exposes fm_sum and frame_done; the mask logic is shared, not duplicated.

Test Plan:
- Slots 0..5 each L=R=10'd100; PSG=16'h9000 strobed first; fm_en=psg_en=1; defaults. Expected: out_l=out_r=16'h2980 (9600+1024), out_valid 2 MCLK after the slot-5 strobe.
- Slots 0..5 each 10'h1FF; PSG=16'h8000. Expected: out=16'h7FFF (49056 saturated). Repeat with 10'h200 each. Expected: out=16'h8000 (-49152 saturated).
- Slot sequence 0,1,2,5. Expected: no out_valid, drop_cnt=1. Then 256 further bad frames. Expected: drop_cnt holds at 8'hFF.
- Slots 0,1,2, then 0..5 at value 10'd10 (restart), with index 6/7 strobes interleaved. Expected: out=16'h03C0 (960) with PSG mid, drop_cnt=0.
- fm_en=0 with PSG=16'h0000. Expected: out=16'hE000 (-8192). Then psg_en=0. Expected: out=16'h0000. A PSG strobe on the mix cycle must use the old value.
- SRES low after slot 3 of a frame, released, then a full frame of 10'd1. Expected: out=16'h0060 with PSG mid, drop_cnt=0, all outputs 0 during reset.
